// File: rtl/block_search_ctrl.sv
// Scans RAM words 0..last through the read-data stage, comparing each against a key word.
// Reports the first match and the first minimum; any read that times out aborts the scan with o_err.
module block_search_ctrl #(
    parameter int SIZE_DATA = 8,
    parameter int SIZE_ADDR = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic                 i_clk,
    input  logic                 w_rst_sel_data_rd,
    input  logic                 i_start,
    input  logic [SIZE_ADDR-1:0] i_key_addr,
    input  logic [SIZE_ADDR-1:0] i_last_addr,
    output logic                 o_rd_en,
    output logic [1:0]           o_sel_data_rd,
    output logic [SIZE_ADDR-1:0] o_addr,
    input  logic                 i_done,
    input  logic [SIZE_DATA-1:0] i_data_key,
    input  logic [SIZE_DATA-1:0] i_temp_data,
    output logic                 o_busy,
    output logic                 o_found,
    output logic [SIZE_ADDR-1:0] o_match_idx,
    output logic [SIZE_DATA-1:0] o_min,
    output logic [SIZE_ADDR-1:0] o_min_idx,
    output logic                 o_valid,
    output logic                 o_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, REQ_KEY, WAIT_KEY, REQ_DATA, WAIT_DATA, CMP, DONE
    } state_t;

    state_t               state, state_nx;
    logic [SIZE_ADDR-1:0] key_addr_q, last_q, addr_q;
    logic [SIZE_DATA-1:0] key_q, data_q;
    logic [CW-1:0]        cnt_q;
    logic                 to_hit;

    // i_done wins over the timeout in the final wait cycle
    assign to_hit = (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge w_rst_sel_data_rd) begin
        if (!w_rst_sel_data_rd) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:      if (i_start) state_nx = REQ_KEY;
            REQ_KEY:   state_nx = WAIT_KEY;
            WAIT_KEY: begin
                if (i_done)      state_nx = REQ_DATA;
                else if (to_hit) state_nx = DONE;
            end
            REQ_DATA:  state_nx = WAIT_DATA;
            WAIT_DATA: begin
                if (i_done)      state_nx = CMP;
                else if (to_hit) state_nx = DONE;
            end
            CMP:       state_nx = (addr_q == last_q) ? DONE : REQ_DATA;
            DONE:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge w_rst_sel_data_rd) begin
        if (!w_rst_sel_data_rd) begin
            key_addr_q  <= '0;
            last_q      <= '0;
            addr_q      <= '0;
            key_q       <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            o_found     <= 1'b0;
            o_match_idx <= '0;
            o_min       <= '0;
            o_min_idx   <= '0;
            o_err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        key_addr_q  <= i_key_addr;
                        last_q      <= i_last_addr;
                        o_found     <= 1'b0;
                        o_match_idx <= '0;
                        o_min       <= '0;
                        o_min_idx   <= '0;
                        o_err       <= 1'b0;
                    end
                end
                REQ_KEY, REQ_DATA: cnt_q <= '0;
                WAIT_KEY: begin
                    if (i_done) begin
                        key_q  <= i_data_key;
                        addr_q <= '0;
                    end else if (to_hit) begin
                        o_err <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                WAIT_DATA: begin
                    if (i_done) begin
                        data_q <= i_temp_data;
                    end else if (to_hit) begin
                        o_err <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                CMP: begin
                    if (addr_q == '0 || data_q < o_min) begin
                        o_min     <= data_q;
                        o_min_idx <= addr_q;
                    end
                    if (data_q == key_q && !o_found) begin
                        o_found     <= 1'b1;
                        o_match_idx <= addr_q;
                    end
                    if (addr_q != last_q) addr_q <= addr_q + SIZE_ADDR'(1);
                end
                default: ;
            endcase
        end
    end

    assign o_busy  = (state != IDLE);
    assign o_valid = (state == DONE);
    assign o_rd_en = (state == REQ_KEY) || (state == REQ_DATA);

    always_comb begin
        o_sel_data_rd = 2'b00;
        o_addr        = '0;
        unique case (state)
            REQ_KEY, WAIT_KEY: begin
                o_sel_data_rd = 2'b01;
                o_addr        = key_addr_q;
            end
            REQ_DATA, WAIT_DATA, CMP: begin
                o_sel_data_rd = 2'b10;
                o_addr        = addr_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_block_search_ctrl.sv
// Bench for block_search_ctrl: a RAM-backed reader responder, a request/result
// reference model and a per-cycle compare process.
module tb_block_search_ctrl;

    logic       i_clk;
    logic       w_rst_sel_data_rd;
    logic       i_start;
    logic [3:0] i_key_addr, i_last_addr;
    logic       o_rd_en;
    logic [1:0] o_sel_data_rd;
    logic [3:0] o_addr;
    logic       i_done;
    logic [7:0] i_data_key, i_temp_data;
    logic       o_busy, o_found, o_valid, o_err;
    logic [3:0] o_match_idx, o_min_idx;
    logic [7:0] o_min;

    block_search_ctrl #(.SIZE_DATA(8), .SIZE_ADDR(4), .TIMEOUT(16)) dut (
        .i_clk(i_clk), .w_rst_sel_data_rd(w_rst_sel_data_rd),
        .i_start(i_start), .i_key_addr(i_key_addr), .i_last_addr(i_last_addr),
        .o_rd_en(o_rd_en), .o_sel_data_rd(o_sel_data_rd), .o_addr(o_addr),
        .i_done(i_done), .i_data_key(i_data_key), .i_temp_data(i_temp_data),
        .o_busy(o_busy), .o_found(o_found), .o_match_idx(o_match_idx),
        .o_min(o_min), .o_min_idx(o_min_idx), .o_valid(o_valid), .o_err(o_err)
    );

    initial i_clk = 0;
    always #5 i_clk = ~i_clk;

    int checks = 0;
    int failures = 0;

    logic [7:0] mem [16];
    int  resp_dly = 1;
    bit  spur = 0;
    bit  withhold = 0;

    logic [1:0] exp_sel [17];
    logic [3:0] exp_addr [17];
    int  exp_nreq, req_idx, valid_cnt, cyc, last_rd_cyc, valid_cyc;
    bit  exp_found, exp_err, hold_chk, prev_rd, prev_valid, run_active;
    logic [3:0] exp_mi, exp_midx;
    logic [7:0] exp_min;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Reference: min value first, then its lowest index; first key match.
    task automatic model(input logic [7:0] key, input int last);
        logic [7:0] mn;
        mn = 8'hFF;
        exp_found = 0; exp_mi = 0; exp_midx = 0;
        for (int i = 0; i <= last; i++) if (mem[i] < mn) mn = mem[i];
        exp_min = mn;
        for (int i = last; i >= 0; i--) if (mem[i] == mn) exp_midx = 4'(i);
        for (int i = last; i >= 0; i--) if (mem[i] == key) begin
            exp_found = 1; exp_mi = 4'(i);
        end
    endtask

    // Reader responder: answers each request after resp_dly cycles.
    initial begin
        logic [1:0] rs;
        logic [3:0] ra;
        i_done = 0; i_data_key = 0; i_temp_data = 0;
        forever begin
            @(negedge i_clk);
            i_done = 0;
            if (o_rd_en && w_rst_sel_data_rd && !(withhold && o_sel_data_rd == 2'b10)) begin
                rs = o_sel_data_rd; ra = o_addr;
                if (spur && rs == 2'b10) begin
                    i_done = 1; i_temp_data = 8'h00;
                    @(negedge i_clk);
                    i_done = 0;
                    repeat (resp_dly - 1) @(negedge i_clk);
                end else begin
                    repeat (resp_dly) @(negedge i_clk);
                end
                if (rs == 2'b01) i_data_key = mem[ra];
                else i_temp_data = mem[ra];
                i_done = 1;
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge i_clk) begin
        cyc++;
        if (w_rst_sel_data_rd && run_active) begin
            if (o_rd_en) begin
                chk("rd_gap", prev_rd, 0);
                if (req_idx < exp_nreq) begin
                    chk("req_sel", o_sel_data_rd, exp_sel[req_idx]);
                    chk("req_addr", o_addr, exp_addr[req_idx]);
                end else begin
                    chk("extra_req", req_idx, exp_nreq);
                end
                req_idx++;
                last_rd_cyc = cyc;
            end
            if (o_valid) begin
                chk("valid_pulse", prev_valid, 0);
                valid_cnt++;
                valid_cyc = cyc;
                chk("nreq", req_idx, exp_nreq);
                hold_chk = 1;
            end
            if (!o_busy) begin
                chk("idle_rd", o_rd_en, 0);
                chk("idle_sel", o_sel_data_rd, 0);
                chk("idle_addr", o_addr, 0);
                chk("idle_valid", o_valid, 0);
            end
            if (!o_busy && hold_chk) begin
                chk("found", o_found, exp_found);
                chk("match_idx", o_match_idx, exp_mi);
                chk("min", o_min, exp_min);
                chk("min_idx", o_min_idx, exp_midx);
                chk("err", o_err, exp_err);
            end
        end
        prev_rd = o_rd_en;
        prev_valid = o_valid;
    end

    task automatic start_scan(input logic [3:0] ka, input logic [3:0] la);
        hold_chk = 0;
        if (withhold) begin
            exp_found = 0; exp_mi = 0; exp_min = 0; exp_midx = 0;
            exp_err = 1; exp_nreq = 2;
        end else begin
            model(mem[ka], int'(la));
            exp_err = 0; exp_nreq = int'(la) + 2;
        end
        exp_sel[0] = 2'b01; exp_addr[0] = ka;
        for (int i = 0; i < 16; i++) begin
            exp_sel[i+1] = 2'b10; exp_addr[i+1] = 4'(i);
        end
        req_idx = 0; valid_cnt = 0;
        @(negedge i_clk);
        i_key_addr = ka; i_last_addr = la; i_start = 1;
        @(negedge i_clk);
        i_start = 0; i_key_addr = ~ka; i_last_addr = ~la;
    endtask

    task automatic wait_result(input string nm);
        for (int c = 0; c < 2000 && valid_cnt == 0; c++) @(negedge i_clk);
        if (valid_cnt == 0) chk({nm, "_valid_seen"}, 0, 1);
        repeat (3) @(negedge i_clk);
        chk({nm, "_valid_once"}, valid_cnt, 1);
    endtask

    initial begin
        w_rst_sel_data_rd = 0; i_start = 0; i_key_addr = 0; i_last_addr = 0;
        cyc = 0; run_active = 0; hold_chk = 0; req_idx = 0; valid_cnt = 0;
        for (int i = 0; i < 16; i++) mem[i] = 8'(i * 37 + 11);
        #2;
        chk("rst_busy", o_busy, 0);
        chk("rst_outs", {o_rd_en, o_sel_data_rd, o_addr, o_found, o_match_idx,
                         o_min, o_min_idx, o_valid, o_err}, 0);
        repeat (3) @(negedge i_clk);
        w_rst_sel_data_rd = 1;
        run_active = 1;

        // Key 5 over {9,5,2,5}
        mem[0] = 9; mem[1] = 5; mem[2] = 2; mem[3] = 5; mem[10] = 5;
        resp_dly = 1;
        start_scan(4'd10, 4'd3);
        wait_result("t1");
        chk("t1_found", o_found, 1);
        chk("t1_match_idx", o_match_idx, 1);
        chk("t1_min", o_min, 2);
        chk("t1_min_idx", o_min_idx, 2);

        // Single element, no match
        mem[0] = 7; mem[11] = 3; resp_dly = 2;
        start_scan(4'd11, 4'd0);
        wait_result("t2");
        chk("t2_found", o_found, 0);
        chk("t2_min", o_min, 7);
        chk("t2_min_idx", o_min_idx, 0);
        chk("t2_nreq", req_idx, 2);

        // Ties keep earliest index
        mem[0] = 4; mem[1] = 4; mem[2] = 4; mem[12] = 4; resp_dly = 1;
        start_scan(4'd12, 4'd2);
        wait_result("t3");
        chk("t3_min_idx", o_min_idx, 0);
        chk("t3_match_idx", o_match_idx, 0);
        chk("t3_found", o_found, 1);

        // Spurious i_done in REQ_DATA and i_start while busy
        mem[0] = 8; mem[1] = 3; mem[2] = 6; mem[3] = 3; mem[4] = 1; mem[5] = 1;
        mem[13] = 6; resp_dly = 3; spur = 1;
        start_scan(4'd13, 4'd5);
        repeat (6) @(negedge i_clk);
        i_start = 1; i_key_addr = 4'd0; i_last_addr = 4'd15;
        @(negedge i_clk);
        i_start = 0;
        wait_result("t4");
        spur = 0;
        chk("t4_match_idx", o_match_idx, 2);
        chk("t4_min", o_min, 1);
        chk("t4_min_idx", o_min_idx, 4);

        // i_done on the last permitted wait cycle is a success
        mem[0] = 200; mem[1] = 100; mem[14] = 100; resp_dly = 16;
        start_scan(4'd14, 4'd1);
        wait_result("t5");
        chk("t5_err", o_err, 0);
        chk("t5_match_idx", o_match_idx, 1);

        // Withheld data read times out
        resp_dly = 1; withhold = 1;
        start_scan(4'd10, 4'd2);
        wait_result("t6");
        withhold = 0;
        chk("t6_err", o_err, 1);
        chk("t6_found", o_found, 0);
        chk("t6_latency", valid_cyc - last_rd_cyc, 17);

        // Reset in the middle of WAIT_DATA
        for (int i = 0; i < 16; i++) mem[i] = 8'(i * 37 + 11);
        resp_dly = 5;
        start_scan(4'd15, 4'd3);
        for (int c = 0; c < 200 && req_idx < 3; c++) @(negedge i_clk);
        chk("t7_reached", req_idx, 3);
        repeat (2) @(negedge i_clk);
        run_active = 0;
        w_rst_sel_data_rd = 0;
        #1;
        chk("t7_busy", o_busy, 0);
        chk("t7_outs", {o_rd_en, o_sel_data_rd, o_addr, o_found, o_match_idx,
                        o_min, o_min_idx, o_valid, o_err}, 0);
        repeat (3) @(negedge i_clk);
        chk("t7_no_valid", o_valid, 0);
        w_rst_sel_data_rd = 1;
        exp_found = 0; exp_mi = 0; exp_min = 0; exp_midx = 0; exp_err = 0;
        hold_chk = 1;
        run_active = 1;
        repeat (10) @(negedge i_clk);

        resp_dly = 1;
        start_scan(4'd15, 4'd15);
        wait_result("t8");
        chk("t8_found", o_found, 1);
        chk("t8_min", o_min, exp_min);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=%0d expected=%0d", 0, 1);
        $fatal(1, "global timeout");
    end

endmodule
